reg_file_arbiter: RTL
=====================

# reg_file_arbiter

Two-requester sequencer for the 32×32 register file's port set (a1/a2/a3/we3/wd3 in, rd1/rd2 out). Arbitrates between the core pipeline (requester 0) and the debug/loader unit (requester 1), runs one read-pair or one write at a time, and returns registered read data. Accounts for the register file's synchronous read: read data is valid one cycle after the address, and no read update happens on a write cycle.

## Interface
- XLEN, 32, data width
- AW, 5, register address width
- clk  in  1  clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- m0_valid / m1_valid  in  1  request present
- m0_we / m1_we  in  1  1 = write, 0 = read pair
- m0_ra1, m0_ra2 / m1_ra1, m1_ra2  in  AW  read addresses
- m0_wa / m1_wa  in  AW  write address
- m0_wd / m1_wd  in  XLEN  write data
- m0_ready / m1_ready  out  1  request accepted this cycle (valid&ready)
- m0_rsp_valid / m1_rsp_valid  out  1  one-cycle completion pulse
- rsp_rd1, rsp_rd2  out  XLEN  read data, shared, valid with rsp_valid
- busy  out  1  state ≠ IDLE
- rf_a1, rf_a2, rf_a3  out  AW  to register file
- rf_we3  out  1  to register file
- rf_wd3  out  XLEN  to register file
- rf_rd1, rf_rd2  in  XLEN  from register file

## Operation
- States: IDLE, ISSUE, CAPT, DONE.
- IDLE: readies combinational from arbitration; at most one ready high. On accept, latch we/ra1/ra2/wa/wd and requester id; -> ISSUE.
- ISSUE: drive rf_a1/a2/a3/wd3 from latch; rf_we3 = latched we & (wa ≠ 0). Write -> DONE; read -> CAPT.
- CAPT: rf_we3 = 0, addresses held; register rf_rd1/rf_rd2 into rsp_rd1/rsp_rd2; -> DONE.
- DONE: rsp_valid for latched id high one cycle; -> IDLE. Responses cannot be back-pressured.
- Outside ISSUE, rf_we3 = 0; rf address/data outputs hold last latched values.
- Write to x0: rf_we3 stays 0, response still issued. Read of x0 returns 0 (register file guarantee).
- Write: rsp_rd1/rsp_rd2 keep previous values.
- Requests presented while busy are not accepted (ready 0); requester holds valid.
- Arbitration when both valid in IDLE: see Configuration. Single valid always wins.

## Timing
- Reset values: state IDLE, all readies 0 until out of reset, rsp_valid 0, rsp_rd1/2 0, rf_* 0, busy 0, RR pointer = 0 preferred.
- Accept at edge 0 (end of cycle 0). Write: rf_we3 high cycle 1, rsp_valid cycle 2. Read: rf_a1/a2 cycle 1, data captured end of cycle 2, rsp_valid cycle 3.
- Throughput: write every 3 cycles, read every 4 (IDLE cycle included).
- Reset mid-operation: immediate return to IDLE; in-flight op dropped, no rsp_valid, rf_we3 deasserted asynchronously.
- Valid dropped after accept: no effect, op completes.

## Configuration
- RF_ARB_RR_EN defined: round-robin. Pointer toggles to the other requester after each grant; on conflict the non-last-granted wins.
- Undefined: fixed priority, requester 0 always wins conflicts; pointer logic absent.

## Structure
- Package reg_file_arbiter_pkg: state enum (IDLE, ISSUE, CAPT, DONE), XLEN/AW defaults, requester id constants.
- Sub-module rf_arb_pick: 2-input grant logic (fixed or RR per macro), inputs valids + pointer, output one-hot grant.

## Test plan
- Reset then m0 write wa=5 wd=0xDEADBEEF -> rf_we3 cycle 1 with a3=5, m0_rsp_valid cycle 2; m0 read ra1=5 ra2=0 -> m0_rsp_valid cycle 3 with rsp_rd1=0xDEADBEEF, rsp_rd2=0.
- m1 write wa=0 wd=0x1234 -> rf_we3 never high, m1_rsp_valid cycle 2; read x0 -> 0.
- Both valid every cycle, reads: without RF_ARB_RR_EN grants m0,m0,m0…; with it grants m0,m1,m0,m1.
- Write then read issued back-to-back by m0 -> second ready only after DONE; read returns new data.
- rst asserted during CAPT of m1 read -> no m1_rsp_valid, busy 0 next cycle, rsp_rd1/2 = 0.
- m1 read while m0 holds valid during busy -> m0_ready 0 until IDLE, then granted per arbitration mode.

Source files
------------

// File: rtl/reg_file_arbiter_pkg.sv
// Shared types and constants for the register-file arbiter.
// Optional round-robin arbitration is enabled by defining RF_ARB_RR_EN.
package reg_file_arbiter_pkg;

  localparam int DEF_XLEN = 32;
  localparam int DEF_AW   = 5;

  localparam logic REQ_M0 = 1'b0;
  localparam logic REQ_M1 = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    CAPT  = 2'd2,
    DONE  = 2'd3
  } state_e;

  // One-hot response strobe for a requester id.
  function automatic logic [1:0] rsp_onehot(input logic id);
    return (id == REQ_M1) ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/rf_arb_pick.sv
// Two-input grant logic: fixed priority (m0 wins) or, with RF_ARB_RR_EN,
// round-robin where ptr_i names the requester preferred on conflict.
module rf_arb_pick
  import reg_file_arbiter_pkg::*;
(
  input  logic [1:0] valid_i,
  input  logic       ptr_i,
  output logic [1:0] grant_o
);

`ifdef RF_ARB_RR_EN
  always_comb begin
    grant_o = valid_i;
    if (valid_i == 2'b11) begin
      grant_o = ptr_i ? 2'b10 : 2'b01;
    end
  end
`else
  logic ptr_unused;
  assign ptr_unused = ptr_i;
  assign grant_o    = {valid_i[1] & ~valid_i[0], valid_i[0]};
`endif

endmodule

// File: rtl/reg_file_arbiter.sv
// Sequences read-pair / write requests from two masters onto a synchronous-read
// register file. Define RF_ARB_RR_EN for round-robin instead of fixed priority.
module reg_file_arbiter
  import reg_file_arbiter_pkg::*;
#(
  parameter int XLEN = DEF_XLEN,
  parameter int AW   = DEF_AW
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            m0_valid,
  input  logic            m0_we,
  input  logic [AW-1:0]   m0_ra1,
  input  logic [AW-1:0]   m0_ra2,
  input  logic [AW-1:0]   m0_wa,
  input  logic [XLEN-1:0] m0_wd,
  output logic            m0_ready,
  output logic            m0_rsp_valid,
  input  logic            m1_valid,
  input  logic            m1_we,
  input  logic [AW-1:0]   m1_ra1,
  input  logic [AW-1:0]   m1_ra2,
  input  logic [AW-1:0]   m1_wa,
  input  logic [XLEN-1:0] m1_wd,
  output logic            m1_ready,
  output logic            m1_rsp_valid,
  output logic [XLEN-1:0] rsp_rd1,
  output logic [XLEN-1:0] rsp_rd2,
  output logic            busy,
  output logic [AW-1:0]   rf_a1,
  output logic [AW-1:0]   rf_a2,
  output logic [AW-1:0]   rf_a3,
  output logic            rf_we3,
  output logic [XLEN-1:0] rf_wd3,
  input  logic [XLEN-1:0] rf_rd1,
  input  logic [XLEN-1:0] rf_rd2
);

  state_e          state_q;
  logic            id_q;
  logic            we_q;
  logic            we3_q;
  logic [AW-1:0]   ra1_q, ra2_q, wa_q;
  logic [XLEN-1:0] wd_q, rd1_q, rd2_q;
  logic [1:0]      rsp_v_q;

  logic [1:0]      grant;
  logic            accept;
  logic            ptr;
  logic            sel_d;
  logic            we_d;
  logic [AW-1:0]   ra1_d, ra2_d, wa_d;
  logic [XLEN-1:0] wd_d;

  rf_arb_pick u_pick (
    .valid_i ({m1_valid, m0_valid}),
    .ptr_i   (ptr),
    .grant_o (grant)
  );

  // Readies are only offered in IDLE and never while reset is held.
  assign accept   = (state_q == IDLE) && !rst && (grant != 2'b00);
  assign m0_ready = accept & grant[0];
  assign m1_ready = accept & grant[1];

  assign sel_d = grant[1];
  assign we_d  = sel_d ? m1_we  : m0_we;
  assign ra1_d = sel_d ? m1_ra1 : m0_ra1;
  assign ra2_d = sel_d ? m1_ra2 : m0_ra2;
  assign wa_d  = sel_d ? m1_wa  : m0_wa;
  assign wd_d  = sel_d ? m1_wd  : m0_wd;

`ifdef RF_ARB_RR_EN
  logic ptr_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= REQ_M0;
    end else if (accept) begin
      ptr_q <= ~sel_d;
    end
  end
  assign ptr = ptr_q;
`else
  assign ptr = REQ_M0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      id_q    <= REQ_M0;
      we_q    <= 1'b0;
      we3_q   <= 1'b0;
      ra1_q   <= '0;
      ra2_q   <= '0;
      wa_q    <= '0;
      wd_q    <= '0;
      rd1_q   <= '0;
      rd2_q   <= '0;
      rsp_v_q <= 2'b00;
    end else begin
      case (state_q)
        IDLE: begin
          rsp_v_q <= 2'b00;
          if (accept) begin
            id_q    <= sel_d;
            we_q    <= we_d;
            ra1_q   <= ra1_d;
            ra2_q   <= ra2_d;
            wa_q    <= wa_d;
            wd_q    <= wd_d;
            // x0 is hardwired: suppress the strobe but still complete.
            we3_q   <= we_d && (wa_d != '0);
            state_q <= ISSUE;
          end
        end
        ISSUE: begin
          we3_q <= 1'b0;
          if (we_q) begin
            rsp_v_q <= rsp_onehot(id_q);
            state_q <= DONE;
          end else begin
            state_q <= CAPT;
          end
        end
        CAPT: begin
          rd1_q   <= rf_rd1;
          rd2_q   <= rf_rd2;
          rsp_v_q <= rsp_onehot(id_q);
          state_q <= DONE;
        end
        DONE: begin
          rsp_v_q <= 2'b00;
          state_q <= IDLE;
        end
        default: begin
          we3_q   <= 1'b0;
          rsp_v_q <= 2'b00;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy         = (state_q != IDLE);
  assign m0_rsp_valid = rsp_v_q[0];
  assign m1_rsp_valid = rsp_v_q[1];
  assign rsp_rd1      = rd1_q;
  assign rsp_rd2      = rd2_q;
  assign rf_a1        = ra1_q;
  assign rf_a2        = ra2_q;
  assign rf_a3        = wa_q;
  assign rf_we3       = we3_q;
  assign rf_wd3       = wd_q;

endmodule
